// File: rtl/bayer_mosaic.sv
`default_nettype none
// ============================================================================
//  Module   : bayer_mosaic
//  Purpose  : Re-samples a 24-bit RGB AXI4-Stream video frame into an 8-bit
//             Bayer (CFA) AXI4-Stream. Line framing on the output is
//             regenerated from internal row/column counters; malformed input
//             framing (misplaced tuser, early or missing tlast) is flagged
//             with one-cycle pulses and the counters resynchronise.
//  Ports    : clk, rst (async, active-high)
//             s_axis_*  : RGB slave  (tdata = R[23:16] G[15:8] B[7:0])
//             m_axis_*  : Bayer master (tdata = selected 8-bit sample)
//             frame_done    : last pixel of the frame handed off downstream
//             err_sof       : tuser seen away from row 0 / col 0
//             err_eol_early : tlast seen before the last column
//             err_eol_late  : last column reached without tlast
//  Revision : 1.0 - initial release
// ============================================================================
module bayer_mosaic #(
  parameter int Nrows         = 480,
  parameter int Ncol          = 640,
  parameter int BAYER_PATTERN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic [23:0] s_axis_tdata,
  output logic        s_axis_tready,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  input  logic        m_axis_tready,
  output logic        frame_done,
  output logic        err_sof,
  output logic        err_eol_early,
  output logic        err_eol_late
);

  // Counter widths; a single-row or single-column frame still needs one bit.
  localparam int CW = (Ncol  > 1) ? $clog2(Ncol)  : 1;
  localparam int RW = (Nrows > 1) ? $clog2(Nrows) : 1;
  // Beat payload: {frame_last, tuser, tlast, sample[7:0]}
  localparam int PW = 11;

  localparam logic [CW-1:0] c_col_last = CW'(Ncol - 1);
  localparam logic [RW-1:0] c_row_last = RW'(Nrows - 1);
  localparam logic [1:0]    c_pat      = 2'(BAYER_PATTERN);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_tready;
  logic          r_skid_full;
  logic [PW-1:0] r_skid;
  logic [PW-1:0] r_out;
  logic          r_m_valid;
  logic          r_err_sof;
  logic          r_err_early;
  logic          r_err_late;

  logic          w_accept;
  logic          w_out_free;
  logic          w_skid_full_nxt;
  logic [CW-1:0] w_eff_col;
  logic [RW-1:0] w_eff_row;
  logic          w_at_origin;
  logic          w_col_end;
  logic          w_line_end;
  logic          w_frame_last;
  logic [1:0]    w_phase;
  logic [7:0]    w_sample;
  logic [PW-1:0] w_beat;

  assign w_accept   = s_axis_tvalid & r_tready;
  assign w_out_free = ~r_m_valid | m_axis_tready;

  // tuser forces the beat to be treated as the frame origin, whatever the
  // counters currently say.
  assign w_eff_col    = s_axis_tuser ? '0 : r_col;
  assign w_eff_row    = s_axis_tuser ? '0 : r_row;
  assign w_at_origin  = (w_eff_row == '0) && (w_eff_col == '0);
  assign w_col_end    = (w_eff_col == c_col_last);
  // A line ends either at the last column or on an early tlast.
  assign w_line_end   = w_col_end | s_axis_tlast;
  assign w_frame_last = w_line_end & (w_eff_row == c_row_last);

  // CFA phase: bit1 = row parity, bit0 = column parity, both offset by the
  // configured pattern so phase 00 is always the red site.
  assign w_phase = {w_eff_row[0] ^ c_pat[1], w_eff_col[0] ^ c_pat[0]};

  always_comb begin
    w_sample = s_axis_tdata[15:8];
    case (w_phase)
      2'b00:   w_sample = s_axis_tdata[23:16];
      2'b11:   w_sample = s_axis_tdata[7:0];
      default: w_sample = s_axis_tdata[15:8];
    endcase
  end

  assign w_beat = {w_frame_last, w_at_origin, w_line_end, w_sample};

  // The skid only fills when a beat is accepted while the output is stalled;
  // it always empties as soon as the output register frees up.
  assign w_skid_full_nxt = w_out_free ? 1'b0 : (r_skid_full | w_accept);

  // Position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_line_end) begin
        r_col <= '0;
        r_row <= (w_eff_row == c_row_last) ? '0 : w_eff_row + 1'b1;
      end else begin
        r_col <= w_eff_col + 1'b1;
        r_row <= w_eff_row;
      end
    end
  end

  // Output register + one-entry skid buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_m_valid   <= 1'b0;
      r_skid      <= '0;
      r_skid_full <= 1'b0;
      r_tready    <= 1'b0;
    end else begin
      r_skid_full <= w_skid_full_nxt;
      r_tready    <= ~w_skid_full_nxt;
      if (w_out_free) begin
        if (r_skid_full) begin
          // tready was low, so no new beat can arrive this cycle
          r_out     <= r_skid;
          r_m_valid <= 1'b1;
        end else if (w_accept) begin
          r_out     <= w_beat;
          r_m_valid <= 1'b1;
        end else begin
          r_m_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid <= w_beat;
      end
    end
  end

  // Framing error pulses, one cycle per offending accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sof   <= 1'b0;
      r_err_early <= 1'b0;
      r_err_late  <= 1'b0;
    end else begin
      r_err_sof   <= w_accept & s_axis_tuser & ((r_row != '0) | (r_col != '0));
      r_err_early <= w_accept & s_axis_tlast & ~w_col_end;
      r_err_late  <= w_accept & w_col_end & ~s_axis_tlast;
    end
  end

  assign s_axis_tready = r_tready;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_out[7:0];
  assign m_axis_tlast  = r_out[8];
  assign m_axis_tuser  = r_out[9];
  // Coincides with the downstream handshake of the frame's final pixel.
  assign frame_done    = r_m_valid & m_axis_tready & r_out[10];
  assign err_sof       = r_err_sof;
  assign err_eol_early = r_err_early;
  assign err_eol_late  = r_err_late;

endmodule
`default_nettype wire

// File: tb/tb_bayer_mosaic.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bayer_mosaic
//  Purpose  : Self-checking bench for bayer_mosaic. Two 4x4 instances (RGGB
//             and BGGR) share one input stream and one downstream ready;
//             expected beats are queued at input acceptance and popped by an
//             independent output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bayer_mosaic;

  localparam int NR = 4;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_user  = 1'b0;
  logic        s_last  = 1'b0;
  logic [23:0] s_data  = '0;
  logic        m_ready = 1'b1;

  logic       tready0, mvalid0, muser0, mlast0, fdone0, esof0, eearly0, elate0;
  logic [7:0] mdata0;
  logic       tready3, mvalid3, muser3, mlast3, fdone3, esof3, eearly3, elate3;
  logic [7:0] mdata3;

  always #5 clk = ~clk;

  bayer_mosaic #(.Nrows(NR), .Ncol(NC), .BAYER_PATTERN(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tuser(s_user), .s_axis_tlast(s_last),
    .s_axis_tdata(s_data), .s_axis_tready(tready0),
    .m_axis_tvalid(mvalid0), .m_axis_tuser(muser0), .m_axis_tlast(mlast0),
    .m_axis_tdata(mdata0), .m_axis_tready(m_ready),
    .frame_done(fdone0), .err_sof(esof0), .err_eol_early(eearly0),
    .err_eol_late(elate0)
  );

  bayer_mosaic #(.Nrows(NR), .Ncol(NC), .BAYER_PATTERN(3)) dut3 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tuser(s_user), .s_axis_tlast(s_last),
    .s_axis_tdata(s_data), .s_axis_tready(tready3),
    .m_axis_tvalid(mvalid3), .m_axis_tuser(muser3), .m_axis_tlast(mlast3),
    .m_axis_tdata(mdata3), .m_axis_tready(m_ready),
    .frame_done(fdone3), .err_sof(esof3), .err_eol_early(eearly3),
    .err_eol_late(elate3)
  );

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d3;
    logic       user;
    logic       last;
    logic       fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   bp_mode = 0;
  int   m_row = 0;
  int   m_col = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Colour at a site: red on (even,even) of the phase grid, blue on (odd,odd).
  function automatic logic [7:0] chan(input int pat, input int row, input int col,
                                      input logic [23:0] d);
    int p;
    p = (((row % 2) ^ (pat / 2)) * 2) + ((col % 2) ^ (pat % 2));
    if (p == 0) return d[23:16];
    if (p == 3) return d[7:0];
    return d[15:8];
  endfunction

  // Drive one beat, wait for acceptance, queue its expectation, check errors.
  task automatic send(input logic [23:0] d, input logic u, input logic l);
    exp_t e;
    int   er, ec, waited;
    bit   eol, x_sof, x_early, x_late;
    logic w;
    er      = u ? 0 : m_row;
    ec      = u ? 0 : m_col;
    x_sof   = u && (m_row != 0 || m_col != 0);
    eol     = (ec == NC - 1) || l;
    x_early = l && (ec < NC - 1);
    x_late  = (ec == NC - 1) && !l;
    e.d0    = chan(0, er, ec, d);
    e.d3    = chan(3, er, ec, d);
    e.user  = (er == 0) && (ec == 0);
    e.last  = eol;
    e.fl    = eol && (er == NR - 1);

    s_valid = 1'b1; s_data = d; s_user = u; s_last = l;
    waited = 0;
    forever begin
      w = tready0;
      chk("tready_match", tready3, w);
      @(posedge clk); #1;
      if (w) break;
      waited++;
      if (waited > 1000) begin
        $display("FAIL accept_timeout: got no accept, expected accept within 1000 cycles");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
      end
    end
    sb.push_back(e);
    s_valid = 1'b0;
    if (eol) begin
      m_col = 0;
      m_row = (er + 1) % NR;
    end else begin
      m_col = ec + 1;
      m_row = er;
    end
    chk("err_flags0", {esof0, eearly0, elate0}, {x_sof, x_early, x_late});
    chk("err_flags3", {esof3, eearly3, elate3}, {x_sof, x_early, x_late});
    if (bp_mode == 0) begin
      chk("latency1_valid", mvalid0, 1'b1);
      chk("tready_unstalled", tready0, 1'b1);
    end
  endtask

  task automatic send_ok(input logic [23:0] d);
    send(d, (m_row == 0 && m_col == 0), (m_col == NC - 1));
  endtask

  // Downstream ready: constant 1 or random 50%, changed just after each edge
  initial begin
    forever begin
      @(posedge clk); #1;
      m_ready = (bp_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Output monitor / scoreboard
  logic        hold_v = 1'b0;
  logic [10:0] hold_beat;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      chk("valid_match", mvalid3, mvalid0);
      if (hold_v) chk("stall_stable", {mvalid0, muser0, mlast0, mdata0}, hold_beat);
      if (mvalid0 && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("data_rggb", mdata0, e.d0);
          chk("data_bggr", mdata3, e.d3);
          chk("tuser", {muser0, muser3}, {e.user, e.user});
          chk("tlast", {mlast0, mlast3}, {e.last, e.last});
          chk("frame_done", {fdone0, fdone3}, {e.fl, e.fl});
        end
      end else begin
        chk("frame_done_idle", {fdone0, fdone3}, 2'b00);
      end
      hold_v    = mvalid0 && !m_ready;
      hold_beat = {mvalid0, muser0, mlast0, mdata0};
    end
  end

  initial begin
    int waited;
    logic u, l;
    // Reset held with valid asserted: everything must stay quiet
    rst = 1'b1; s_valid = 1'b1; s_data = 24'h123456;
    repeat (20) begin
      @(posedge clk); #1;
      chk("reset_outputs0", {tready0, mvalid0, muser0, mlast0, mdata0, fdone0,
                             esof0, eearly0, elate0}, '0);
      chk("reset_outputs3", {tready3, mvalid3, muser3, mlast3, mdata3, fdone3,
                             esof3, eearly3, elate3}, '0);
    end
    s_valid = 1'b0;
    rst = 1'b0;
    chk("tready_before_edge", tready0, 1'b0);
    @(posedge clk); #1;
    chk("tready_after_release", {tready0, tready3}, 2'b11);

    // Clean 4x4 frame, continuous valid, no backpressure
    for (int i = 0; i < 16; i++)
      send({8'(8'h10 + i), 8'h80, 8'(8'hF0 - i)}, (i == 0), (i % 4 == 3));
    repeat (3) @(posedge clk);
    #1;

    // Directed framing errors
    send(24'hA1B2C3, 1'b1, 1'b0);
    send(24'hA2B3C4, 1'b0, 1'b0);
    send(24'hA3B4C5, 1'b0, 1'b1);          // early tlast at col 2
    for (int c = 0; c < 4; c++)
      send({8'(c), 8'h55, 8'(8'hE0 + c)}, 1'b0, 1'b0);  // tlast omitted at col 3
    send(24'h010203, 1'b0, 1'b0);
    send(24'h040506, 1'b0, 1'b0);
    send(24'h070809, 1'b1, 1'b0);          // tuser mid-line at row 2 col 2
    while (!(m_row == 0 && m_col == 0)) send_ok(24'($urandom));
    for (int i = 0; i < 16; i++) send_ok(24'($urandom));
    repeat (3) @(posedge clk);
    #1;

    // Random data, random backpressure, occasional framing corruption
    bp_mode = 1;
    for (int i = 0; i < 320; i++) begin
      u = (m_row == 0 && m_col == 0);
      l = (m_col == NC - 1);
      if ($urandom_range(0, 15) == 0) u = ~u;
      if ($urandom_range(0, 15) == 0) l = ~l;
      send(24'($urandom), u, l);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    while (!(m_row == 0 && m_col == 0)) send_ok(24'($urandom));

    // Reset in the middle of a frame (row 2), then a clean frame
    for (int i = 0; i < 10; i++) send_ok(24'($urandom));
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_clear", {tready0, mvalid0, mlast0, mdata0, tready3, mvalid3}, '0);
    sb.delete();
    m_row = 0;
    m_col = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) send_ok(24'($urandom));

    // Drain
    bp_mode = 0;
    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
